// File: rtl/stark_fpu_wb_sequencer_if.sv
// Station/FPU/regfile/ROB signal bundle for the FPU writeback sequencer.
// The slave side is the sequencer; the master side is its environment.
interface stark_fpu_wb_sequencer_if #(
    parameter int WID   = 64,
    parameter int PREGW = 9,
    parameter int AREGW = 7,
    parameter int RNDXW = 5
);
    logic             in_valid;
    logic [RNDXW-1:0] in_id;
    logic [PREGW-1:0] in_Rt;
    logic [PREGW-1:0] in_Rt1;
    logic [AREGW-1:0] in_aRt;
    logic             in_aRtz;
    logic [AREGW-1:0] in_aRt1;
    logic             in_aRtz1;
    logic             in_qfext;
    logic [7:0]       in_cptgt;
    logic [WID-1:0]   in_argT;
    logic             flush;
    logic             fpu_start;
    logic             fpu_abort;
    logic             fpu_done;
    logic [WID-1:0]   fpu_res;
    logic [WID-1:0]   fpu_res1;
    logic             fpu_exc;
    logic             wb_v;
    logic [PREGW-1:0] wb_Rt;
    logic [AREGW-1:0] wb_aRt;
    logic [WID-1:0]   wb_res;
    logic             wb_ack;
    logic             idle;
    logic             cmp_v;
    logic [RNDXW-1:0] cmp_id;
    logic [1:0]       cmp_exc;

    modport master (
        output in_valid, in_id, in_Rt, in_Rt1, in_aRt, in_aRtz, in_aRt1, in_aRtz1,
               in_qfext, in_cptgt, in_argT, flush, fpu_done, fpu_res, fpu_res1,
               fpu_exc, wb_ack,
        input  fpu_start, fpu_abort, wb_v, wb_Rt, wb_aRt, wb_res, idle, cmp_v,
               cmp_id, cmp_exc
    );

    modport slave (
        input  in_valid, in_id, in_Rt, in_Rt1, in_aRt, in_aRtz, in_aRt1, in_aRtz1,
               in_qfext, in_cptgt, in_argT, flush, fpu_done, fpu_res, fpu_res1,
               fpu_exc, wb_ack,
        output fpu_start, fpu_abort, wb_v, wb_Rt, wb_aRt, wb_res, idle, cmp_v,
               cmp_id, cmp_exc
    );
endinterface

// File: rtl/stark_fpu_wb_sequencer.sv
// FPU writeback sequencer: launches one op, waits for done/timeout, issues one or
// two regfile writebacks over valid/ack, then pulses ROB completion.
module stark_fpu_wb_sequencer #(
    parameter int WID   = 64,
    parameter int PREGW = 9,
    parameter int AREGW = 7,
    parameter int RNDXW = 5,
    parameter int TMO   = 63
) (
    input logic                       clk,
    input logic                       rst,
    stark_fpu_wb_sequencer_if.slave   bus
);
    localparam int TMRW = $clog2(TMO + 1);

    typedef enum logic [2:0] {S_IDLE, S_BUSY, S_WB0, S_WB1, S_CMP} state_t;

    state_t           r_state, w_next;
    logic [RNDXW-1:0] r_id;
    logic [PREGW-1:0] r_Rt, r_Rt1;
    logic [AREGW-1:0] r_aRt, r_aRt1;
    logic             r_aRtz, r_aRtz1, r_qfext;
    logic [WID-1:0]   r_res0, r_res1;
    logic [1:0]       r_exc;
    logic [TMRW-1:0]  r_timer;
    logic             r_idle, r_fpu_start, r_fpu_abort;
    logic             w_accept, w_timeout;

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid && !bus.flush;
    // done arriving in the same cycle as the limit takes priority over timeout
    assign w_timeout = (r_state == S_BUSY) && !bus.fpu_done && (r_timer == TMRW'(TMO));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (bus.in_cptgt != 8'd0) ? S_WB0 : S_BUSY;
            S_BUSY: if (bus.fpu_done || w_timeout) w_next = S_WB0;
            S_WB0:  if (r_aRtz || bus.wb_ack)
                        w_next = (r_qfext && (r_exc != 2'b10)) ? S_WB1 : S_CMP;
            S_WB1:  if (r_aRtz1 || bus.wb_ack) w_next = S_CMP;
            S_CMP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idle      <= 1'b1;
            r_fpu_start <= 1'b0;
            r_fpu_abort <= 1'b0;
            r_id        <= '0;
            r_Rt        <= '0;
            r_Rt1       <= '0;
            r_aRt       <= '0;
            r_aRt1      <= '0;
            r_aRtz      <= 1'b0;
            r_aRtz1     <= 1'b0;
            r_qfext     <= 1'b0;
            r_res0      <= '0;
            r_res1      <= '0;
            r_exc       <= 2'b00;
            r_timer     <= '0;
        end else begin
            r_state     <= w_next;
            r_idle      <= (w_next == S_IDLE);
            r_fpu_start <= w_accept && (bus.in_cptgt == 8'd0);
            r_fpu_abort <= (r_state == S_BUSY) && (bus.flush || w_timeout);
            if (w_accept) begin
                r_id    <= bus.in_id;
                r_Rt    <= bus.in_Rt;
                r_Rt1   <= bus.in_Rt1;
                r_aRt   <= bus.in_aRt;
                r_aRt1  <= bus.in_aRt1;
                r_aRtz  <= bus.in_aRtz;
                r_aRtz1 <= bus.in_aRtz1;
                r_qfext <= bus.in_qfext;
                r_res0  <= bus.in_argT;
                r_res1  <= '0;
                r_exc   <= 2'b00;
                r_timer <= '0;
            end else if ((r_state == S_BUSY) && !bus.flush) begin
                r_timer <= r_timer + 1'b1;
                if (bus.fpu_done) begin
                    r_res0 <= bus.fpu_res;
                    r_res1 <= bus.fpu_res1;
                    r_exc  <= bus.fpu_exc ? 2'b01 : 2'b00;
                end else if (w_timeout) begin
                    r_exc  <= 2'b10;
                    r_res0 <= '0;
                end
            end
        end
    end

    // Writeback fields are muxed straight from the latched op so they stay
    // stable for as long as the regfile withholds ack.
    assign bus.wb_v      = ((r_state == S_WB0) && !r_aRtz) || ((r_state == S_WB1) && !r_aRtz1);
    assign bus.wb_Rt     = (r_state == S_WB1) ? r_Rt1  : r_Rt;
    assign bus.wb_aRt    = (r_state == S_WB1) ? r_aRt1 : r_aRt;
    assign bus.wb_res    = (r_state == S_WB1) ? r_res1 : r_res0;
    assign bus.fpu_start = r_fpu_start;
    assign bus.fpu_abort = r_fpu_abort;
    assign bus.idle      = r_idle;
    assign bus.cmp_v     = (r_state == S_CMP) && !bus.flush;
    assign bus.cmp_id    = r_id;
    assign bus.cmp_exc   = r_exc;
endmodule

// File: doc/stark_fpu_wb_sequencer.md
Name: stark_fpu_wb_sequencer

Overview:
Downstream of the FPU reservation station. Accepts a fully-operand-valid FPU op from the station, launches it on the external FPU datapath (or bypasses it for copy-target ops), waits for completion or timeout, then sequences one or two register-file writebacks (two when qfext) over a valid/ack writeback port. It drives the station's idle input and reports completion and exceptions to the ROB.

Parameters:
WID, 64, operand/result width (value_t)
PREGW, 9, physical register number width
AREGW, 7, architectural register number width
RNDXW, 5, ROB index width
TMO, 63, max cycles to wait for fpu_done before raising a timeout exception

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  station all_args_valid
in_id  in  RNDXW  ROB index of op
in_Rt  in  PREGW  primary dest preg
in_Rt1  in  PREGW  second dest preg (qfext)
in_aRt  in  AREGW  primary arch dest
in_aRtz  in  1  primary dest is r0
in_aRt1  in  AREGW  second arch dest
in_aRtz1  in  1  second dest is r0
in_qfext  in  1  op writes two results
in_cptgt  in  8  copy-target mask; nonzero = bypass FPU
in_argT  in  WID  old target value for copy-target
flush  in  1  pipeline flush (branch miss)
fpu_start  out  1  one-cycle launch pulse
fpu_abort  out  1  one-cycle abort pulse
fpu_done  in  1  datapath result valid
fpu_res  in  WID  primary result
fpu_res1  in  WID  second result
fpu_exc  in  1  datapath exception
wb_v  out  1  writeback valid
wb_Rt  out  PREGW  writeback preg
wb_aRt  out  AREGW  writeback arch reg
wb_res  out  WID  writeback data
wb_ack  in  1  regfile accepted writeback
idle  out  1  ready for a new op (to station)
cmp_v  out  1  one-cycle ROB completion pulse
cmp_id  out  RNDXW  ROB index completed
cmp_exc  out  2  00 none, 01 FPU exception, 10 timeout

Behaviour:
- Reset (rst=0, async): state IDLE; idle=1; wb_v, fpu_start, fpu_abort, cmp_v=0; wb_Rt, wb_aRt, wb_res, cmp_id, cmp_exc, timer=0.
- States: IDLE, BUSY, WB0, WB1, CMP.
- IDLE & in_valid & !flush: latch all in_* fields; idle<=0. If in_cptgt!=0: res0<=in_argT, go WB0, no fpu_start. Else fpu_start=1 for exactly the next cycle, timer<=0, go BUSY.
- BUSY: timer increments each cycle. fpu_done: latch fpu_res/fpu_res1, exc<=fpu_exc?01:00, go WB0. timer==TMO with no done: exc<=10, fpu_abort pulse, res0<=0, go WB0 (second write suppressed). fpu_done at timer==TMO: done wins.
- WB0: skipped (straight to WB1/CMP) when aRtz. Else wb_v=1, wb_Rt=Rt, wb_aRt=aRt, wb_res=res0; held stable until wb_ack sampled high. On ack: go WB1 if qfext and exc!=10, else CMP.
- WB1: same with Rt1/aRt1/res1; skipped if aRtz1. On ack -> CMP.
- wb_v deasserts the cycle after the ack cycle; no back-to-back duplicate writes.
- CMP: cmp_v=1 one cycle with cmp_id and cmp_exc; idle<=1; go IDLE. Latency minimum: copy-target with r0 dest = 2 cycles in_valid->cmp_v.
- idle is registered; high only in IDLE. in_valid while not IDLE ignored.
- flush (any state except IDLE): next state IDLE, wb_v=0, no cmp_v; fpu_abort pulse if in BUSY. flush with wb_ack same cycle: flush wins, ack ignored (regfile write for that cycle still occurs externally; ROB entry is discarded anyway).
- flush with in_valid in IDLE: op not accepted.
- Reset mid-operation: immediate return to reset values, no pulses.

Test Plan:
- Simple op: in_valid, cptgt=0, Rt=5, aRt=3, fpu_done 4 cycles after fpu_start with res=0x3FF0000000000000, wb_ack immediate -> one wb_v with Rt=5 data 0x3FF0..., cmp_v id matches, cmp_exc=00, idle back high.
- qfext: res=0x11, res1=0x22, Rt=7, Rt1=8, wb_ack delayed 3 cycles each -> wb_v held stable, two writes in order (7,0x11),(8,0x22), single cmp_v.
- Copy-target: cptgt=0xFF, argT=0xABCD -> no fpu_start, write 0xABCD to Rt, cmp_v within 3 cycles of in_valid with wb_ack tied high.
- Timeout: TMO=63, fpu_done never -> fpu_abort at timer 63, write 0 to Rt only (qfext set), cmp_exc=10.
- Flush in BUSY and in WB0 (with concurrent wb_ack) -> fpu_abort/ no abort respectively, no cmp_v, idle=1 next cycle; subsequent op completes normally.
- aRtz=1, fpu_exc=1 -> no wb_v, cmp_exc=01; async reset asserted mid-WB0 -> wb_v drops immediately.
